// File: rtl/mux4to1_rr_arb.sv
// mux4to1_rr_arb: 4-way round-robin arbiter with a bounded hold time,
// steering the granted requester's data bit through a registered 4:1 mux.
// A requester that keeps asserting req keeps the grant until it has held
// it for MAX_HOLD cycles while someone else waits. A sole requester keeps
// the grant indefinitely.

module mux4to1_rr_arb #(
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic [3:0] in,
   output logic [3:0] gnt,
   output logic [1:0] sel,
   output logic       valid,
   output logic       out
);

   // Wide enough to hold the values 0..MAX_HOLD
   localparam int unsigned HCW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [HCW-1:0] HOLD_MAX = HCW'(MAX_HOLD);
   localparam logic [HCW-1:0] HOLD_ONE = HCW'(1);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;
   logic [3:0]       gnt_q, gnt_d;
   logic [1:0]       sel_q, sel_d;
   logic             valid_q, valid_d;
   logic             out_q, out_d;

   logic [1:0]       pick;
   logic             pick_any;
   logic [1:0]       scan_idx;
   logic [3:0]       sel_onehot;
   logic             others_pend;
   logic             cur_req;
   logic             take_pick;

   // Round-robin search: first requester at or after ptr, wrapping mod 4
   always_comb begin
      pick     = '0;
      pick_any = 1'b0;
      scan_idx = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         scan_idx = ptr_q + 2'(i);
         if (!pick_any && req[scan_idx]) begin
            pick     = scan_idx;
            pick_any = 1'b1;
         end
      end
   end

   // Status of the current owner and of everyone else
   always_comb begin
      sel_onehot  = 4'b0001 << sel_q;
      cur_req     = req[sel_q];
      others_pend = |(req & ~sel_onehot);
   end

   // Next-state, grant and registered mux datapath
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      hold_cnt_d = hold_cnt_q;
      gnt_d      = gnt_q;
      sel_d      = sel_q;
      take_pick  = 1'b0;

      // Output stage lags the grant by one edge and samples in at that edge
      valid_d = (state_q == GRANT);
      out_d   = (state_q == GRANT) ? in[sel_q] : 1'b0;

      unique case (state_q)
         IDLE: begin
            if (pick_any) begin
               take_pick = 1'b1;
            end else begin
               gnt_d = '0;
            end
         end
         GRANT: begin
            if (!cur_req) begin
               // Owner released: hand over directly, or go idle if nobody waits
               if (pick_any) begin
                  take_pick = 1'b1;
               end else begin
                  state_d    = IDLE;
                  gnt_d      = '0;
                  hold_cnt_d = '0;
               end
            end else if ((hold_cnt_q == HOLD_MAX) && others_pend) begin
               // ptr already points past the owner, so the pick is another requester
               take_pick = 1'b1;
            end else if (hold_cnt_q != HOLD_MAX) begin
               hold_cnt_d = hold_cnt_q + HOLD_ONE;
            end
         end
      endcase

      if (take_pick) begin
         state_d    = GRANT;
         gnt_d      = 4'b0001 << pick;
         sel_d      = pick;
         hold_cnt_d = HOLD_ONE;
         ptr_d      = pick + 2'd1;
      end
   end

   // State and output registers, asynchronously cleared
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         hold_cnt_q <= '0;
         gnt_q      <= '0;
         sel_q      <= '0;
         valid_q    <= 1'b0;
         out_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         hold_cnt_q <= hold_cnt_d;
         gnt_q      <= gnt_d;
         sel_q      <= sel_d;
         valid_q    <= valid_d;
         out_q      <= out_d;
      end
   end

   assign gnt   = gnt_q;
   assign sel   = sel_q;
   assign valid = valid_q;
   assign out   = out_q;

   a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(gnt_q));

   a_sel_matches_gnt: assert property (@(posedge clk) disable iff (!rst_n)
      (gnt_q != '0) |-> gnt_q[sel_q]);

endmodule

// File: tb/tb_mux4to1_rr_arb.sv
// Bench for mux4to1_rr_arb: reference model + scoreboard, directed scenarios
// and randomized request/data traffic.

module tb_mux4to1_rr_arb;

   localparam int MAX_HOLD = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = '0;
   logic [3:0] din = '0;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       valid;
   logic       out_bit;

   int errors = 0;
   int checks = 0;

   mux4to1_rr_arb #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .in    (din),
      .gnt   (gnt),
      .sel   (sel),
      .valid (valid),
      .out   (out_bit)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] gnt;
      logic [1:0] sel;
      logic       valid;
      logic       out;
   } exp_t;

   exp_t sb_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: who owns the grant, for how long, and where the search starts
   int m_owner;   // -1 when nobody is granted
   int m_sel;
   int m_ptr;
   int m_hold;

   function automatic int rr_pick(input logic [3:0] r, input int p);
      for (int i = 0; i < 4; i++) begin
         int k;
         k = (p + i) % 4;
         if (r[k]) return k;
      end
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_owner = -1;
         m_sel   = 0;
         m_ptr   = 0;
         m_hold  = 0;
      end else begin
         exp_t e;
         logic [3:0] r;
         logic [3:0] others;
         bit new_grant;
         r = req;
         new_grant = 1'b0;
         e.valid = (m_owner >= 0);
         e.out   = e.valid ? din[m_sel] : 1'b0;
         if (m_owner < 0 || !r[m_owner]) begin
            if (r != 4'b0000) new_grant = 1'b1;
            else begin
               m_owner = -1;
               m_hold  = 0;
            end
         end else begin
            others = r & ~(4'b0001 << m_owner);
            if (m_hold == MAX_HOLD && others != 4'b0000) new_grant = 1'b1;
            else if (m_hold < MAX_HOLD) m_hold = m_hold + 1;
         end
         if (new_grant) begin
            m_owner = rr_pick(r, m_ptr);
            m_sel   = m_owner;
            m_hold  = 1;
            m_ptr   = (m_owner + 1) % 4;
         end
         e.gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
         e.sel = m_sel[1:0];
         sb_q.push_back(e);
      end
   end

   // Monitor: compare every registered output once per cycle, away from the edge
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         check("sb_gnt",   gnt,     e.gnt);
         check("sb_sel",   sel,     e.sel);
         check("sb_valid", valid,   e.valid);
         check("sb_out",   out_bit, e.out);
      end
   end

   task automatic reset_dut();
      @(negedge clk);
      #2 rst_n = 1'b0;
      req = '0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      // Reset state while rst_n is low
      #12;
      check("rst_gnt",   gnt,     4'b0000);
      check("rst_sel",   sel,     2'd0);
      check("rst_valid", valid,   1'b0);
      check("rst_out",   out_bit, 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b1;

      // Single requester 2: grant after edge 1, data after edge 2
      req = 4'b0100;
      din = 4'b0100;
      @(negedge clk);
      check("lat_gnt",    gnt,   4'b0100);
      check("lat_sel",    sel,   2'd2);
      check("lat_valid0", valid, 1'b0);
      @(negedge clk);
      check("lat_valid1", valid,   1'b1);
      check("lat_out1",   out_bit, 1'b1);

      // Asynchronous reset mid-grant takes effect before the next edge
      #2 rst_n = 1'b0;
      #1;
      check("async_gnt",   gnt,     4'b0000);
      check("async_valid", valid,   1'b0);
      check("async_out",   out_bit, 1'b0);
      check("async_sel",   sel,     2'd0);
      req = '0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;

      // All requesting: rotation 0,1,2,3,0 with MAX_HOLD cycles each
      req = 4'b1111;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         din = 4'($urandom_range(0, 15));
         check("rot_gnt", gnt, 4'b0001 << ((c / MAX_HOLD) % 4));
      end

      // Owner 0 releases with 2 pending: direct handover, valid stays high
      reset_dut();
      req = 4'b0001;
      @(negedge clk);
      check("ho_gnt0", gnt, 4'b0001);
      @(negedge clk);
      check("ho_valid0", valid, 1'b1);
      req = 4'b0100;
      @(negedge clk);
      check("ho_gnt2", gnt, 4'b0100);
      check("ho_valid1", valid, 1'b1);
      @(negedge clk);
      check("ho_valid2", valid, 1'b1);

      // Everyone releases: grant drops, valid drops one edge later
      req = 4'b0000;
      @(negedge clk);
      check("rel_gnt",    gnt,   4'b0000);
      check("rel_valid1", valid, 1'b1);
      @(negedge clk);
      check("rel_valid0", valid, 1'b0);

      // Pointer wraps after requester 3; sole requester is never preempted
      req = 4'b1000;
      @(negedge clk);
      check("wrap_gnt3", gnt, 4'b1000);
      req = 4'b0000;
      @(negedge clk);
      check("wrap_idle", gnt, 4'b0000);
      req = 4'b1001;
      @(negedge clk);
      check("wrap_gnt0", gnt, 4'b0001);
      check("wrap_sel0", sel, 2'd0);
      req = 4'b0001;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("sole_gnt", gnt, 4'b0001);
      end

      // Randomized traffic; requests change occasionally so holds build up
      for (int b = 0; b < 3; b++) begin
         reset_dut();
         for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            din = 4'($urandom_range(0, 15));
         end
      end

      req = '0;
      repeat (2) @(negedge clk);
      #1;
      check("sb_drained", sb_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
